// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/bubble arbitration with optional perf counters
// Optional feature macro: PIPE_HAZARD_PERF_EN (compiles in stall_cycles/bubble_count/flush_count)
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_valid,
  input  logic        id_rs2_valid,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rd_valid,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        icache_stall,
  input  logic        dcache_stall,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        id_ex_hazard_stall,
  output logic        cache_stall,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_count,
  output logic [31:0] flush_count
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_BUBBLE     = 2'd1;
  localparam logic [1:0] ST_CACHE_WAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH      = 2'd3;

  logic       pending_flush;
  logic       load_use;
  logic       flush_now;
  logic       bubble_now;
  logic [1:0] state_q;
  logic [1:0] state_d;

  // x0 is never a real producer, so it can never cause a load-use hazard
  assign load_use = ex_is_load & ex_rd_valid & (ex_rd_addr != 5'd0) &
                    ((id_rs1_valid & (id_rs1_addr == ex_rd_addr)) |
                     (id_rs2_valid & (id_rs2_addr == ex_rd_addr)));

  assign cache_stall = icache_stall | dcache_stall;
  assign flush_now   = ~cache_stall & (ex_branch_taken | pending_flush);
  assign bubble_now  = ~cache_stall & ~flush_now & load_use;

  assign pc_stall           = cache_stall | bubble_now;
  assign if_id_stall        = cache_stall | bubble_now;
  assign if_id_flush        = flush_now;
  assign id_ex_flush        = flush_now;
  assign id_ex_hazard_stall = bubble_now;

  // A redirect arriving during a miss is remembered and replayed once on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_flush <= 1'b0;
    end else if (cache_stall) begin
      pending_flush <= pending_flush | ex_branch_taken;
    end else begin
      pending_flush <= 1'b0;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (cache_stall) begin
      state_d = ST_CACHE_WAIT;
    end else if (flush_now) begin
      state_d = ST_FLUSH;
    end else if (bubble_now) begin
      state_d = ST_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctrl_state = state_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] bubble_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= 32'd0;
      bubble_q <= 32'd0;
      flush_q  <= 32'd0;
    end else begin
      if (cache_stall) stall_q  <= stall_q + 32'd1;
      if (bubble_now)  bubble_q <= bubble_q + 32'd1;
      if (flush_now)   flush_q  <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_count = bubble_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign bubble_count = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_valid, id_rs2_valid, ex_rd_valid, ex_is_load;
  logic        ex_branch_taken, icache_stall, dcache_stall;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic        id_ex_hazard_stall, cache_stall;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles, bubble_count, flush_count;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_valid(id_rs1_valid), .id_rs2_valid(id_rs2_valid),
    .ex_rd_addr(ex_rd_addr), .ex_rd_valid(ex_rd_valid), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .id_ex_hazard_stall(id_ex_hazard_stall), .cache_stall(cache_stall),
    .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       v1, v2, rdv, ld, br, ic, dc;
  } in_t;

  typedef struct {
    in_t        i;
    logic       e_hz, e_fl, e_ps, e_cs;
    logic [1:0] e_state;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: one action per cycle chosen by priority, plus a remembered redirect
  int          m_act;
  logic        m_pend;
  logic [1:0]  m_state;
  logic [31:0] m_stall, m_bub, m_fl;
  logic        cur_br, cur_cs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int model_act(input in_t x, input logic pend);
    bit lu;
    lu = x.ld && x.rdv && (x.rd != 0) &&
         ((x.v1 && x.rs1 == x.rd) || (x.v2 && x.rs2 == x.rd));
    if (x.ic || x.dc) return 2;
    if (x.br || pend) return 3;
    if (lu) return 1;
    return 0;
  endfunction

  task automatic drive(input in_t x);
    id_rs1_addr = x.rs1; id_rs2_addr = x.rs2; ex_rd_addr = x.rd;
    id_rs1_valid = x.v1; id_rs2_valid = x.v2; ex_rd_valid = x.rdv;
    ex_is_load = x.ld; ex_branch_taken = x.br;
    icache_stall = x.ic; dcache_stall = x.dc;
  endtask

  task automatic apply(input in_t x);
    @(negedge clk);
    drive(x);
    #1;
    m_act  = model_act(x, m_pend);
    cur_br = x.br;
    cur_cs = x.ic | x.dc;
    chk("cache_stall", cache_stall, cur_cs);
    chk("pc_stall", pc_stall, m_act == 2 || m_act == 1);
    chk("if_id_stall", if_id_stall, m_act == 2 || m_act == 1);
    chk("if_id_flush", if_id_flush, m_act == 3);
    chk("id_ex_flush", id_ex_flush, m_act == 3);
    chk("id_ex_hazard_stall", id_ex_hazard_stall, m_act == 1);
  endtask

  task automatic check_counters();
`ifdef PIPE_HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("bubble_count", bubble_count, m_bub);
    chk("flush_count", flush_count, m_fl);
`else
    chk("stall_cycles", stall_cycles, 32'd0);
    chk("bubble_count", bubble_count, 32'd0);
    chk("flush_count", flush_count, 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    m_pend  = cur_cs ? (m_pend | cur_br) : 1'b0;
    m_state = 2'(m_act);
    if (m_act == 2) m_stall++;
    if (m_act == 1) m_bub++;
    if (m_act == 3) m_fl++;
    #1;
    chk("ctrl_state", ctrl_state, m_state);
    check_counters();
  endtask

  task automatic model_reset();
    m_pend = 0; m_state = 0; m_stall = 0; m_bub = 0; m_fl = 0;
  endtask

  task automatic do_reset();
    in_t z;
    z = '{default: '0};
    @(negedge clk);
    rst_n = 1'b0;
    drive(z);
    model_reset();
    #1;
    chk("reset_state", ctrl_state, 2'd0);
    check_counters();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic in_t mk(input logic [4:0] rs1, input logic v1, input logic [4:0] rs2,
                             input logic v2, input logic [4:0] rd, input logic rdv,
                             input logic ld, input logic br, input logic ic, input logic dc);
    in_t x;
    x.rs1 = rs1; x.v1 = v1; x.rs2 = rs2; x.v2 = v2; x.rd = rd; x.rdv = rdv;
    x.ld = ld; x.br = br; x.ic = ic; x.dc = dc;
    return x;
  endfunction

  vec_t tbl[12];
  in_t  idle;
  in_t  lu5;

  initial begin
    rst_n = 1'b0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu5  = mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    drive(idle);
    model_reset();
    m_act = 0; cur_br = 0; cur_cs = 0;

    //                 inputs                                  hz fl ps cs state
    tbl[0]  = '{idle,                                          0, 0, 0, 0, 2'd0};
    tbl[1]  = '{lu5,                                           1, 0, 1, 0, 2'd1};
    tbl[2]  = '{mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0),              0, 0, 0, 0, 2'd0};
    tbl[3]  = '{mk(3, 1, 7, 1, 7, 1, 1, 0, 0, 0),              1, 0, 1, 0, 2'd1};
    tbl[4]  = '{mk(3, 1, 7, 0, 7, 1, 1, 0, 0, 0),              0, 0, 0, 0, 2'd0};
    tbl[5]  = '{mk(5, 1, 0, 0, 5, 1, 0, 0, 0, 0),              0, 0, 0, 0, 2'd0};
    tbl[6]  = '{mk(5, 1, 0, 0, 5, 0, 1, 0, 0, 0),              0, 0, 0, 0, 2'd0};
    tbl[7]  = '{mk(5, 1, 0, 0, 5, 1, 1, 1, 0, 0),              0, 1, 0, 0, 2'd3};
    tbl[8]  = '{mk(5, 1, 0, 0, 5, 1, 1, 0, 1, 0),              0, 0, 1, 1, 2'd2};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),              0, 0, 1, 1, 2'd2};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),              0, 1, 0, 0, 2'd3};
    tbl[11] = '{idle,                                          0, 0, 0, 0, 2'd0};

    do_reset();
    for (int k = 0; k < 12; k++) begin
      apply(tbl[k].i);
      chk($sformatf("tbl%0d_hz", k), id_ex_hazard_stall, tbl[k].e_hz);
      chk($sformatf("tbl%0d_flush", k), if_id_flush, tbl[k].e_fl);
      chk($sformatf("tbl%0d_pc_stall", k), pc_stall, tbl[k].e_ps);
      chk($sformatf("tbl%0d_cache", k), cache_stall, tbl[k].e_cs);
      tick();
      chk($sformatf("tbl%0d_state", k), ctrl_state, tbl[k].e_state);
    end

    // Branch during a three-cycle data miss: one flush on release
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    chk("miss_c1_flush", if_id_flush, 1'b0);
    tick();
    for (int c = 2; c <= 3; c++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      chk($sformatf("miss_c%0d_flush", c), id_ex_flush, 1'b0);
      tick();
    end
    apply(idle);
    chk("miss_c4_flush", if_id_flush, 1'b1);
    chk("miss_c4_pc_stall", pc_stall, 1'b0);
    tick();
    chk("miss_c4_state", ctrl_state, 2'd3);
    apply(idle);
    chk("miss_c5_noflush", if_id_flush, 1'b0);
    tick();
`ifdef PIPE_HAZARD_PERF_EN
    chk("miss_flush_count", flush_count, 32'd1);
    chk("miss_stall_cycles", stall_cycles, 32'd3);
`endif

    // Branch also high in the release cycle: still a single flush
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tick();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    chk("rel_br_flush", if_id_flush, 1'b1);
    tick();
    apply(idle);
    chk("rel_br_single", if_id_flush, 1'b0);
    tick();

    // Flush coincident with load-use discards the bubble
    do_reset();
    apply(mk(5, 1, 0, 0, 5, 1, 1, 1, 0, 0));
    chk("coinc_flush", id_ex_flush, 1'b1);
    chk("coinc_hz", id_ex_hazard_stall, 1'b0);
    tick();
`ifdef PIPE_HAZARD_PERF_EN
    chk("coinc_bubble_count", bubble_count, 32'd0);
`endif

    // Reset asserted mid-miss drops the remembered redirect
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    drive(idle);
    #1;
    chk("rstmiss_flush_in_reset", if_id_flush, 1'b0);
    chk("rstmiss_state_in_reset", ctrl_state, 2'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(idle);
    chk("rstmiss_flush_after", if_id_flush, 1'b0);
    tick();
    chk("rstmiss_state_after", ctrl_state, 2'd0);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_t r;
      r.rs1 = 5'($urandom_range(0, 3));
      r.rs2 = 5'($urandom_range(0, 3));
      r.rd  = 5'($urandom_range(0, 3));
      r.v1  = 1'($urandom_range(0, 1));
      r.v2  = 1'($urandom_range(0, 1));
      r.rdv = 1'($urandom_range(0, 3) != 0);
      r.ld  = 1'($urandom_range(0, 1));
      r.br  = 1'($urandom_range(0, 6) == 0);
      r.ic  = 1'($urandom_range(0, 5) == 0);
      r.dc  = 1'($urandom_range(0, 5) == 0);
      apply(r);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
